ram_readback_seq: RTL and testbench
===================================

RAM_READBACK_SEQ -- requirements
Module: ram_readback_seq

Interface
REQ-001 SHALL have parameter DWELL, default 50000000, clock cycles each entry is shown (legal range 1..2^26).
REQ-002 SHALL have parameter AW, default 4, RAM address width; depth is 2^AW.
REQ-003 SHALL have parameter DW, default 8, RAM data width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port clr_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a readback pass.
REQ-007 SHALL have port pause  input  1  level; freezes the dwell counter and index while high.
REQ-008 SHALL have port n_valid  input  AW+1  number of RAM entries to show (0..2^AW).
REQ-009 SHALL have port rd_addr  output  AW  address to the single-port RAM (combinational read).
REQ-010 SHALL have port rd_data  input  DW  RAM data_out for rd_addr, same cycle.
REQ-011 SHALL have port disp_val  output  DW  value for the seven-segment driver.
REQ-012 SHALL have port disp_idx  output  AW  index of disp_val.
REQ-013 SHALL have port disp_valid  output  1  disp_val holds a read entry.
REQ-014 SHALL have port busy  output  1  pass in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-016 SHALL have ports max_val / min_val  output  DW  each; sum_val  output  DW+AW  (pass statistics).

Function
REQ-017 SHALL implement states IDLE, SHOW, DONE; busy=1 only in SHOW.
REQ-018 IDLE: start=1 with n_valid>0 SHALL latch n_valid, set idx=0, dwell=0, clear stats, enter SHOW.
REQ-019 IDLE: start=1 with n_valid=0 SHALL enter DONE directly; stats zero, disp_valid=0.
REQ-020 n_valid > 2^AW SHALL be saturated to 2^AW when latched; later n_valid changes SHALL be ignored until the next start.
REQ-021 SHOW: rd_addr SHALL equal idx; in the cycle dwell==0 (and pause=0), rd_data SHALL be captured into disp_val, idx into disp_idx, disp_valid set, stats updated; visible 1 cycle after idx changes.
REQ-022 SHOW: dwell SHALL increment per unpaused cycle; at dwell==DWELL-1, dwell SHALL return to 0 and idx SHALL increment, or the state SHALL go to DONE if idx==latched n_valid-1.
REQ-023 DWELL=1 SHALL show one entry per cycle, with no skipped or repeated entries.
REQ-024 pause=1 SHALL hold idx, dwell, disp_* and stats unchanged; it SHALL have no effect in IDLE/DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE; disp_val/disp_idx/disp_valid/stats SHALL hold until next start or reset.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 rd_addr SHALL be 0 in IDLE and DONE.
REQ-028 Stats: max_val = unsigned maximum, min_val = unsigned minimum, sum_val = unsigned sum of captured entries; sum SHALL NOT overflow (DW+AW bits); first capture SHALL load max=min=sum=entry.

Reset
REQ-029 clr_n=0 at a rising edge SHALL force IDLE, idx=0, dwell=0, disp_val=0, disp_idx=0, disp_valid=0, done=0, busy=0, max/min/sum=0; it SHALL override start and pause.
REQ-030 Reset mid-pass SHALL abort the pass with no done pulse.

Configuration
REQ-031 Macro RDBK_STATS_EN defined: statistics logic SHALL be built per REQ-028.
REQ-032 RDBK_STATS_EN undefined: max_val, min_val, sum_val SHALL be constant 0, with no statistics registers; all other behaviour SHALL be unchanged.

Verification (DWELL=3, AW=4, DW=8, RAM[0..3]=0x10,0x2A,0x05,0xFF)
REQ-033 Reset, start with n_valid=4: disp_val SHALL show 0x10,0x2A,0x05,0xFF for 3 cycles each; done SHALL pulse 1 cycle after the 12th SHOW cycle; with RDBK_STATS_EN, max=0xFF, min=0x05, sum=0x13E.
REQ-034 start with n_valid=0: done SHALL pulse the next cycle; busy SHALL stay 0; disp_valid SHALL be 0.
REQ-035 pause high for 5 cycles during entry 1: entry 1 SHALL be shown 8 cycles; the total pass SHALL be 17 cycles; stats SHALL be unchanged from REQ-033.
REQ-036 n_valid=20, all RAM=0xFF: exactly 16 entries SHALL be shown; sum SHALL be 0xFF0; no wrap to index 0.
REQ-037 clr_n low during entry 2, then start is repeated: no done pulse for the aborted pass; the new pass SHALL begin at index 0 with stats cleared.
REQ-038 Build without RDBK_STATS_EN and rerun REQ-033: the disp_* sequence SHALL be identical; max/min/sum SHALL be constant 0.

Source files
------------

// File: rtl/ram_readback_seq.sv
// Steps through the first n_valid RAM entries and holds each one for DWELL cycles on a display.
// Define RDBK_STATS_EN to build the max/min/sum pass statistics.
module ram_readback_seq #(
    parameter int unsigned DWELL = 50000000,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             pause,
    input  logic [AW:0]      n_valid,
    output logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    rd_data,
    output logic [DW-1:0]    disp_val,
    output logic [AW-1:0]    disp_idx,
    output logic             disp_valid,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    max_val,
    output logic [DW-1:0]    min_val,
    output logic [DW+AW-1:0] sum_val
);

    localparam int unsigned Depth  = 2 ** AW;
    localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DwellW-1:0] DwellMax = DwellW'(DWELL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     last_q, last_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DW-1:0]     disp_val_q, disp_val_d;
    logic [AW-1:0]     disp_idx_q, disp_idx_d;
    logic              disp_valid_q, disp_valid_d;

    logic              clear;
    logic              capture;
    logic [AW:0]       n_sat;
    logic [AW:0]       n_last;

    // Only the index of the final entry is kept; the count itself is never needed again.
    always_comb begin
        n_sat  = (n_valid > (AW+1)'(Depth)) ? (AW+1)'(Depth) : n_valid;
        n_last = n_sat - (AW+1)'(1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        clear   = 1'b0;
        capture = 1'b0;
        rd_addr = '0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear   = 1'b1;
                    idx_d   = '0;
                    dwell_d = '0;
                    if (n_valid == '0) begin
                        state_d = StDone;
                    end else begin
                        last_d  = n_last[AW-1:0];
                        state_d = StShow;
                    end
                end
            end
            StShow: begin
                busy    = 1'b1;
                rd_addr = idx_q;
                if (!pause) begin
                    capture = (dwell_q == '0);
                    if (dwell_q == DwellMax) begin
                        dwell_d = '0;
                        if (idx_q == last_q) begin
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end else begin
                        dwell_d = dwell_q + DwellW'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        disp_val_d   = disp_val_q;
        disp_idx_d   = disp_idx_q;
        disp_valid_d = disp_valid_q;
        if (clear) begin
            disp_val_d   = '0;
            disp_idx_d   = '0;
            disp_valid_d = 1'b0;
        end else if (capture) begin
            disp_val_d   = rd_data;
            disp_idx_d   = idx_q;
            disp_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            last_q       <= '0;
            dwell_q      <= '0;
            disp_val_q   <= '0;
            disp_idx_q   <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            dwell_q      <= dwell_d;
            disp_val_q   <= disp_val_d;
            disp_idx_q   <= disp_idx_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign disp_val   = disp_val_q;
    assign disp_idx   = disp_idx_q;
    assign disp_valid = disp_valid_q;

`ifdef RDBK_STATS_EN
    logic [DW-1:0]    max_q, max_d;
    logic [DW-1:0]    min_q, min_d;
    logic [DW+AW-1:0] sum_q, sum_d;

    // disp_valid_q is low until the first capture of a pass, so it doubles as the first-entry flag.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        sum_d = sum_q;
        if (clear) begin
            max_d = '0;
            min_d = '0;
            sum_d = '0;
        end else if (capture) begin
            if (!disp_valid_q) begin
                max_d = rd_data;
                min_d = rd_data;
                sum_d = {{AW{1'b0}}, rd_data};
            end else begin
                if (rd_data > max_q) max_d = rd_data;
                if (rd_data < min_q) min_d = rd_data;
                sum_d = sum_q + {{AW{1'b0}}, rd_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            max_q <= '0;
            min_q <= '0;
            sum_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            sum_q <= sum_d;
        end
    end

    assign max_val = max_q;
    assign min_val = min_q;
    assign sum_val = sum_q;
`else
    assign max_val = '0;
    assign min_val = '0;
    assign sum_val = '0;
`endif

    a_done_single : assert property (@(posedge clk) disable iff (!clr_n) done |=> !done);
    a_busy_done_excl : assert property (@(posedge clk) disable iff (!clr_n) !(busy && done));
    a_addr_idle : assert property (@(posedge clk) disable iff (!clr_n) !busy |-> rd_addr == '0);

endmodule

// File: tb/tb_ram_readback_seq.sv
// Directed bench for ram_readback_seq (DWELL=3 and DWELL=1 instances over one RAM model).
module tb_ram_readback_seq;

`ifdef RDBK_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [4:0]  n_valid = '0;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  disp_val;
    logic [3:0]  disp_idx;
    logic        disp_valid;
    logic        busy;
    logic        done;
    logic [7:0]  max_val;
    logic [7:0]  min_val;
    logic [11:0] sum_val;

    logic        start1 = 1'b0;
    logic [4:0]  n_valid1 = '0;
    logic [3:0]  rd_addr1;
    logic [7:0]  rd_data1;
    logic [7:0]  disp_val1;
    logic [3:0]  disp_idx1;
    logic        disp_valid1;
    logic        busy1;
    logic        done1;
    logic [7:0]  max_val1;
    logic [7:0]  min_val1;
    logic [11:0] sum_val1;

    logic [7:0]  ram [16];
    int          total = 0;
    int          bad = 0;

    assign rd_data  = ram[rd_addr];
    assign rd_data1 = ram[rd_addr1];

    always #5 clk = ~clk;

    ram_readback_seq #(.DWELL(3), .AW(4), .DW(8)) u_dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .pause      (pause),
        .n_valid    (n_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .disp_val   (disp_val),
        .disp_idx   (disp_idx),
        .disp_valid (disp_valid),
        .busy       (busy),
        .done       (done),
        .max_val    (max_val),
        .min_val    (min_val),
        .sum_val    (sum_val)
    );

    ram_readback_seq #(.DWELL(1), .AW(4), .DW(8)) u_dut1 (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start1),
        .pause      (1'b0),
        .n_valid    (n_valid1),
        .rd_addr    (rd_addr1),
        .rd_data    (rd_data1),
        .disp_val   (disp_val1),
        .disp_idx   (disp_idx1),
        .disp_valid (disp_valid1),
        .busy       (busy1),
        .done       (done1),
        .max_val    (max_val1),
        .min_val    (min_val1),
        .sum_val    (sum_val1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_ram;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'h10;
        ram[1] = 8'h2A;
        ram[2] = 8'h05;
        ram[3] = 8'hFF;
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        start = 1'b1;
        pause = 1'b1;
        n_valid = 5'd4;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (disp_val !== 8'h00 || disp_idx !== 4'h0 || disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_disp: val=%h idx=%h valid=%b want 00 0 0", disp_val, disp_idx,
                     disp_valid);
        end
        total++;
        if (max_val !== 8'h00 || min_val !== 8'h00 || sum_val !== 12'h000 || rd_addr !== 4'h0)
        begin
            bad++;
            $display("FAIL reset_stats: max=%h min=%h sum=%h addr=%h want all 0", max_val, min_val,
                     sum_val, rd_addr);
        end
        start = 1'b0;
        pause = 1'b0;
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_pass;
        logic [7:0] ev;
        n_valid = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_enter: busy=%b valid=%b want 1 0", busy, disp_valid);
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            ev = ram[(c - 1) / 3];
            total++;
            if (disp_val !== ev || disp_idx !== 4'((c - 1) / 3) || disp_valid !== 1'b1) begin
                bad++;
                $display("FAIL basic_disp c=%0d: val=%h idx=%h valid=%b want %h %h 1", c,
                         disp_val, disp_idx, disp_valid, ev, 4'((c - 1) / 3));
            end
            total++;
            if (busy !== (c < 12) || done !== (c == 12) || rd_addr !== ((c < 12) ? 4'(c / 3) : 4'h0))
            begin
                bad++;
                $display("FAIL basic_ctrl c=%0d: busy=%b done=%b addr=%h want %b %b %h", c, busy,
                         done, rd_addr, c < 12, c == 12, (c < 12) ? 4'(c / 3) : 4'h0);
            end
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || disp_val !== 8'hFF || disp_idx !== 4'h3 ||
            disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold: done=%b busy=%b val=%h idx=%h valid=%b want 0 0 ff 3 1",
                     done, busy, disp_val, disp_idx, disp_valid);
        end
        total++;
        if (max_val !== (StatsOn ? 8'hFF : 8'h00) || min_val !== (StatsOn ? 8'h05 : 8'h00) ||
            sum_val !== (StatsOn ? 12'h13E : 12'h000)) begin
            bad++;
            $display("FAIL basic_stats: max=%h min=%h sum=%h want %h %h %h", max_val, min_val,
                     sum_val, StatsOn ? 8'hFF : 8'h00, StatsOn ? 8'h05 : 8'h00,
                     StatsOn ? 12'h13E : 12'h000);
        end
    endtask

    task automatic test_zero_entries;
        n_valid = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b valid=%b want 1 0 0", done, busy, disp_valid);
        end
        total++;
        if (sum_val !== 12'h000 || max_val !== 8'h00 || min_val !== 8'h00) begin
            bad++;
            $display("FAIL zero_stats: max=%h min=%h sum=%h want 0 0 0", max_val, min_val, sum_val);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_pause;
        int k;
        int idx1_cycles;
        n_valid = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        idx1_cycles = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
            if (disp_valid && disp_idx == 4'h1) idx1_cycles++;
            pause = (k >= 5 && k <= 9);
        end
        pause = 1'b0;
        total++;
        if (k !== 17) begin
            bad++;
            $display("FAIL pause_len: pass cycles=%0d want 17", k);
        end
        total++;
        if (idx1_cycles !== 8) begin
            bad++;
            $display("FAIL pause_entry1: shown=%0d want 8", idx1_cycles);
        end
        total++;
        if (max_val !== (StatsOn ? 8'hFF : 8'h00) || min_val !== (StatsOn ? 8'h05 : 8'h00) ||
            sum_val !== (StatsOn ? 12'h13E : 12'h000)) begin
            bad++;
            $display("FAIL pause_stats: max=%h min=%h sum=%h", max_val, min_val, sum_val);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int k;
        n_valid = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            start = (k == 3);
            n_valid = (k == 3) ? 5'd1 : 5'd4;
            tick();
            k++;
        end
        start = 1'b0;
        total++;
        if (k !== 12) begin
            bad++;
            $display("FAIL b2b_len: pass cycles=%0d want 12", k);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_start: busy=%b done=%b want 0 0", busy, done);
        end
        tick();
        total++;
        if (busy !== 1'b0 || disp_idx !== 4'h3) begin
            bad++;
            $display("FAIL b2b_idle: busy=%b idx=%h want 0 3", busy, disp_idx);
        end
    endtask

    task automatic test_saturate;
        int  k;
        bit  seen_nonzero;
        bit  wrapped;
        for (int i = 0; i < 16; i++) ram[i] = 8'hFF;
        n_valid = 5'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_valid = 5'd2;
        k = 0;
        seen_nonzero = 1'b0;
        wrapped = 1'b0;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
            if (disp_valid && disp_idx == 4'h0 && seen_nonzero) wrapped = 1'b1;
            if (disp_idx != 4'h0) seen_nonzero = 1'b1;
        end
        total++;
        if (k !== 48) begin
            bad++;
            $display("FAIL sat_len: pass cycles=%0d want 48", k);
        end
        total++;
        if (wrapped !== 1'b0 || disp_idx !== 4'hF) begin
            bad++;
            $display("FAIL sat_idx: wrapped=%b idx=%h want 0 f", wrapped, disp_idx);
        end
        total++;
        if (sum_val !== (StatsOn ? 12'hFF0 : 12'h000) || max_val !== (StatsOn ? 8'hFF : 8'h00) ||
            min_val !== (StatsOn ? 8'hFF : 8'h00)) begin
            bad++;
            $display("FAIL sat_stats: max=%h min=%h sum=%h", max_val, min_val, sum_val);
        end
        tick();
        load_default_ram();
    endtask

    task automatic test_abort;
        bit saw_done;
        n_valid = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (disp_idx !== 4'h2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: idx=%h busy=%b want 2 1", disp_idx, busy);
        end
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        total++;
        if (saw_done !== 1'b0 || busy !== 1'b0 || disp_valid !== 1'b0 || sum_val !== 12'h000) begin
            bad++;
            $display("FAIL abort_state: done_seen=%b busy=%b valid=%b sum=%h want 0 0 0 0",
                     saw_done, busy, disp_valid, sum_val);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (disp_idx !== 4'h0 || disp_val !== 8'h10 || disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: idx=%h val=%h valid=%b want 0 10 1", disp_idx, disp_val,
                     disp_valid);
        end
        total++;
        if (sum_val !== (StatsOn ? 12'h010 : 12'h000) || max_val !== (StatsOn ? 8'h10 : 8'h00) ||
            min_val !== (StatsOn ? 8'h10 : 8'h00)) begin
            bad++;
            $display("FAIL abort_stats: max=%h min=%h sum=%h", max_val, min_val, sum_val);
        end
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_dwell1;
        n_valid1 = 5'd4;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (disp_val1 !== ram[c - 1] || disp_idx1 !== 4'(c - 1) || done1 !== (c == 4)) begin
                bad++;
                $display("FAIL dwell1 c=%0d: val=%h idx=%h done=%b want %h %h %b", c, disp_val1,
                         disp_idx1, done1, ram[c - 1], 4'(c - 1), c == 4);
            end
        end
        tick();
        total++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL dwell1_end: done=%b busy=%b want 0 0", done1, busy1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        load_default_ram();
        test_reset();
        test_basic_pass();
        test_zero_entries();
        test_pause();
        test_back_to_back();
        test_saturate();
        test_abort();
        test_dwell1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
